// File: rtl/filter_frame_ctrl.sv
// Frame sequencer for the 3x3 filter: zero-pads the upstream RGB raster, flushes the filter, then pulses its reset.
// Latency: f_iValid/f_iData are registered one cycle after the accepting (or border) cycle.
// Backpressure: s_ready only at interior FEED positions; bubbles hold the raster. FLUSH_TIMEOUT_EN adds a flush watchdog.
module filter_frame_ctrl #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                busy,
    output logic                                frame_done,
    output logic                                out_err,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0]   out_cnt,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [23:0]                         s_data,
    output logic                                f_iValid,
    output logic [23:0]                         f_iData,
    output logic                                f_reset,
    input  logic                                f_oValid,
    input  logic                                f_oDone
`ifdef FLUSH_TIMEOUT_EN
    ,
    output logic                                timeout_err
`endif
);

    localparam int CW  = $clog2(WIDTH + 2);
    localparam int RWD = $clog2(HEIGHT + 2);
    localparam int OW  = $clog2(WIDTH * HEIGHT + 1);
    localparam int KW  = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0]  COL_LAST  = CW'(WIDTH + 1);
    localparam logic [RWD-1:0] ROW_LAST  = RWD'(HEIGHT + 1);
    localparam logic [OW-1:0]  FRAME_PIX = OW'(WIDTH * HEIGHT);
    localparam logic [KW-1:0]  RST_LAST  = KW'(RST_CYCLES - 1);

    if (RST_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
        $error("filter_frame_ctrl: RST_CYCLES and TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, FEED, FLUSH, RST, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   col;
    logic [RWD-1:0]  row;
    logic [KW-1:0]   rst_cnt;
    logic            border, last_pos, advance, flush_exit, timed_out;

    assign border   = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
    assign last_pos = (row == ROW_LAST) && (col == COL_LAST);

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);
    assign f_reset    = reset || (state == RST);

    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        advance    = 1'b0;
        flush_exit = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = FEED;
            FEED: begin
                // Border beats are self-generated; only interior slots consume upstream pixels.
                s_ready = !border && !reset;
                advance = border || (s_valid && s_ready);
                if (advance && last_pos) state_nxt = FLUSH;
            end
            FLUSH: begin
                flush_exit = f_oDone || timed_out;
                if (flush_exit) state_nxt = RST;
            end
            RST:  if (rst_cnt == RST_LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            rst_cnt  <= '0;
            out_cnt  <= '0;
            out_err  <= 1'b0;
            f_iValid <= 1'b0;
            f_iData  <= '0;
        end else begin
            state    <= state_nxt;
            f_iValid <= 1'b0;
            f_iData  <= '0;
            case (state)
                IDLE: if (start) begin
                    row     <= '0;
                    col     <= '0;
                    out_cnt <= '0;
                    out_err <= 1'b0;
                end
                FEED: begin
                    if (advance) begin
                        f_iValid <= 1'b1;
                        f_iData  <= border ? '0 : s_data;
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= last_pos ? '0 : row + RWD'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                    // The filter cannot legitimately finish before the last input beat.
                    if (f_oDone) out_err <= 1'b1;
                end
                FLUSH: begin
                    f_iValid <= !flush_exit;
                    if (f_oDone && (({1'b0, out_cnt} + (OW+1)'(f_oValid)) != {1'b0, FRAME_PIX}))
                        out_err <= 1'b1;
                end
                RST: rst_cnt <= (rst_cnt == RST_LAST) ? '0 : rst_cnt + KW'(1);
                default: ;
            endcase
            if ((state == FEED || state == FLUSH) && f_oValid && (out_cnt != FRAME_PIX))
                out_cnt <= out_cnt + OW'(1);
        end
    end

`ifdef FLUSH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tcnt;

    assign timed_out = (state == FLUSH) && (tcnt == T_LAST) && !f_oDone;

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            tcnt <= (state == FLUSH) ? tcnt + TW'(1) : '0;
            if (state == IDLE && start) timeout_err <= 1'b0;
            else if (timed_out)         timeout_err <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

endmodule

// File: doc/filter_frame_ctrl.md
Name: filter_frame_ctrl

Overview:
- Sequences one frame through the 3x3 `processing` filter.
- Accepts the unpadded RGB pixel stream from upstream over a valid/ready handshake.
- Inserts the one-pixel zero border the filter expects and keeps the filter fed during the pipeline drain.
- Watches the filter's output count and `oDone`, then resets the filter so it is ready for the next frame.

Parameters:
- WIDTH, 320, active pixels per line.
- HEIGHT, 240, active lines per frame.
- RST_CYCLES, 2, length in cycles of the inter-frame filter reset pulse (>=1).
- TIMEOUT, 4096, flush watchdog limit in cycles; used only with FLUSH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; ignored unless the block is IDLE.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.
- out_err  out  1  sticky; set when the output count at `oDone` is not WIDTH*HEIGHT; cleared by start.
- out_cnt  out  $clog2(WIDTH*HEIGHT+1)  filter outputs seen in the current frame.
- s_valid  in  1  upstream pixel valid.
- s_ready  out  1  controller can accept an upstream pixel.
- s_data  in  24  upstream pixel {R,G,B}.
- f_iValid  out  1  to filter `iValid`.
- f_iData  out  24  to filter `iData`.
- f_reset  out  1  to filter `reset`.
- f_oValid  in  1  from filter `oValid`.
- f_oDone  in  1  from filter `oDone`.
- timeout_err  out  1  sticky watchdog flag; present only with FLUSH_TIMEOUT_EN.

Behaviour:
- Reset values:
  - state = IDLE; all counters 0.
  - f_iValid = 0, f_iData = 0, s_ready = 0, busy = 0, frame_done = 0, out_err = 0, out_cnt = 0.
  - f_reset = 1 while `reset` is high (f_reset = reset OR state==RST).
- Padded raster: col counts 0..WIDTH+1 and row counts 0..HEIGHT+1, col fastest. A position is border when row==0, row==HEIGHT+1, col==0 or col==WIDTH+1.
- States: IDLE, FEED, FLUSH, RST, DONE.
- IDLE:
  - start -> FEED.
  - On start: row = col = 0, out_cnt = 0, out_err = 0.
- FEED, border position:
  - Register f_iValid = 1 and f_iData = 0, then advance the position.
  - s_ready = 0.
- FEED, interior position:
  - s_ready = 1. s_ready is decoded from registered state and counters only; it never depends on s_valid.
  - If s_valid: register f_iValid = 1 and f_iData = s_data, then advance.
  - If not s_valid: f_iValid = 0 (bubble) and the position holds.
- FEED exit: advancing from (HEIGHT+1, WIDTH+1) -> FLUSH. Exactly (WIDTH+2)*(HEIGHT+2) beats with f_iValid=1 are issued in FEED.
- Latency: f_iValid/f_iData are registered, one cycle after the s_valid&s_ready cycle or border cycle that produced them.
- FLUSH:
  - f_iValid = 1 and f_iData = 0 every cycle.
  - s_ready = 0.
  - f_oDone sampled high -> RST.
- RST:
  - f_iValid = 0, f_reset = 1 for RST_CYCLES cycles, then -> DONE.
- DONE: frame_done = 1 for one cycle, then -> IDLE.
- Output counter:
  - In FEED and FLUSH, out_cnt increments on each f_oValid.
  - out_cnt saturates at WIDTH*HEIGHT.
  - f_oValid outside FEED/FLUSH is ignored.
- out_err: on the cycle f_oDone is seen in FLUSH, set if (out_cnt + f_oValid) != WIDTH*HEIGHT.
- f_oDone seen during FEED: ignored for sequencing. out_err is set, because a frame cannot be complete before feeding ends.
- start while busy: ignored. start and reset in the same cycle: reset wins.
- reset mid-frame:
  - Returns to IDLE next cycle and clears counters and flags.
  - f_reset is high during reset.
  - Upstream pixels not yet accepted are not consumed; s_ready is low.
- Width rule: f_iData is a straight copy of s_data. There is no arithmetic on pixel data.

Optional Feature:
- Macro FLUSH_TIMEOUT_EN.
- Defined:
  - A counter runs in FLUSH.
  - If f_oDone has not arrived after TIMEOUT cycles, set timeout_err (sticky until start or reset) and force -> RST; frame_done still pulses.
  - Port timeout_err exists.
- Undefined:
  - No counter and no timeout_err port.
  - FLUSH waits for f_oDone indefinitely.

Test Plan:
1. WIDTH=4, HEIGHT=3, s_valid held 1, filter model asserts oValid 12 times then oDone -> exactly 30 f_iValid beats in FEED; beats 0-5, 6, 11, 12, 17, 18, 23 and 24-29 carry 0; interior beats carry s_data in order; out_cnt=12; out_err=0; RST_CYCLES f_reset then one frame_done.
2. Same config, s_valid toggling 1,0,1,0 -> f_iValid drops only at interior positions; border zeros issue regardless of s_valid; the payload order is unchanged; still 30 valid FEED beats.
3. Filter model asserts oDone after only 11 oValid -> out_err=1 after frame_done; next start clears out_err to 0.
4. Assert reset while at row 2, col 3 -> next cycle state IDLE, busy=0, s_ready=0, out_cnt=0; f_reset=1 during reset; start afterwards restarts at row 0, col 0.
5. Pulse start during FLUSH, and pulse start and reset together in IDLE -> no state change in either case; busy stays 0 in the second case.
6. FLUSH_TIMEOUT_EN, TIMEOUT=16, oDone never asserted -> after 16 FLUSH cycles timeout_err=1, f_reset pulses RST_CYCLES, frame_done pulses; without the macro the block remains in FLUSH with f_iValid=1.
